banco_registradores_param: RTL

BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

---
 rtl/banco_registradores_param.sv | 109 ++++++++++
 1 files changed

// File: rtl/banco_registradores_param.sv
// Parameterised register file with two registered read ports, one write
// port with write-first bypass, and a clear sequencer that zeroes every
// register one address per clock.
module banco_registradores_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RegLido1,
  input  logic [ADDR_W-1:0] RegLido2,
  input  logic [ADDR_W-1:0] RegEscr,
  input  logic [DATA_W-1:0] DadoEscr,
  input  logic              RegWrite,
  input  logic              Clear,
  output logic [DATA_W-1:0] Dado1,
  output logic [DATA_W-1:0] Dado2,
  output logic              Busy
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cnt, cnt_next;
  logic [DATA_W-1:0]   br [NREGS];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_load;
  logic [DATA_W-1:0]   rd1_next, rd2_next;

  // Value a read port captures: hardwired zero register first, then the
  // write-first bypass, otherwise the stored content.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (ZERO_REG != 0 && addr == '0) return '0;
    if (we && waddr == addr)         return wdata;
    return stored;
  endfunction

  assign Busy = (state == CLEAR);

  // Next-state, write-port and read-port decode for both controller states.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    wr_addr    = cnt;
    wr_data    = '0;
    rd_load    = 1'b0;
    rd1_next   = '0;
    rd2_next   = '0;
    case (state)
      CLEAR: begin
        // One register zeroed per edge; outputs forced to zero meanwhile.
        wr_en    = 1'b1;
        wr_addr  = cnt;
        cnt_next = cnt + 1'b1;
        rd_load  = 1'b1;
        if (cnt == LAST_ADDR) state_next = IDLE;
      end
      IDLE: begin
        if (Clear) begin
          // Entering clear: the edge that accepts Clear does nothing else.
          state_next = CLEAR;
          cnt_next   = '0;
        end else begin
          wr_en    = RegWrite && !(ZERO_REG != 0 && RegEscr == '0);
          wr_addr  = RegEscr;
          wr_data  = DadoEscr;
          rd_load  = 1'b1;
          rd1_next = read_port(RegLido1, br[RegLido1], RegWrite, RegEscr, DadoEscr);
          rd2_next = read_port(RegLido2, br[RegLido2], RegWrite, RegEscr, DadoEscr);
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Controller, read registers and storage; reset restarts the clear
  // sequence and freezes the array (the array itself has no reset value).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= CLEAR;
      cnt   <= '0;
      Dado1 <= '0;
      Dado2 <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (rd_load) begin
        Dado1 <= rd1_next;
        Dado2 <= rd2_next;
      end
      if (wr_en) br[wr_addr] <= wr_data;
    end
  end

endmodule
